// File: rtl/array_unpack_pkg.sv
// Shared array message type and the unpacker's FSM state encoding.
package top_level_types;
    typedef logic signed [31:0] int_2 [2];
endpackage

package array_unpack_pkg;
    typedef enum logic [1:0] {
        READ  = 2'd0,
        EMIT0 = 2'd1,
        EMIT1 = 2'd2
    } unpack_state_t;
endpackage

// File: rtl/array_unpack.sv
// Takes one two-element array and re-emits its elements one per transfer,
// FIRST_IDX first, over a blocking sync/notify output port.
module array_unpack
    import top_level_types::*;
    import array_unpack_pkg::*;
#(
    parameter int FIRST_IDX = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  int_2               arr_in,
    input  logic               arr_in_sync,
    output logic               arr_in_notify,
    output logic signed [31:0] val_out,
    input  logic               val_out_sync,
    output logic               val_out_notify,
    output logic [1:0]         state_dbg
);

    localparam logic FIRST_SEL  = FIRST_IDX[0];
    localparam logic SECOND_SEL = ~FIRST_SEL;

    unpack_state_t state_q, state_d;
    int_2          buf_q;
    logic          in_xfer, out_xfer;

    // Handshake: a transfer happens on a rising edge where notify (from the
    // block offering or asking) and sync (from the peer) are both high; a sync
    // seen without its notify is ignored. All outputs are registered.
    assign in_xfer   = arr_in_notify && arr_in_sync;
    assign out_xfer  = val_out_notify && val_out_sync;
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            READ:    if (in_xfer)  state_d = EMIT0;
            EMIT0:   if (out_xfer) state_d = EMIT1;
            EMIT1:   if (out_xfer) state_d = READ;
            default: state_d = READ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= READ;
            buf_q          <= '{default: '0};
            val_out        <= '0;
            val_out_notify <= 1'b0;
            arr_in_notify  <= 1'b1;
        end else begin
            state_q <= state_d;
            case (state_q)
                READ: begin
                    if (in_xfer) begin
                        buf_q          <= arr_in;
                        val_out        <= arr_in[FIRST_SEL];
                        val_out_notify <= 1'b1;
                        arr_in_notify  <= 1'b0;
                    end
                end
                EMIT0: begin
                    if (out_xfer) begin
                        val_out <= buf_q[SECOND_SEL];
                    end
                end
                EMIT1: begin
                    // Last element taken: hand the port back to the producer.
                    if (out_xfer) begin
                        val_out_notify <= 1'b0;
                        arr_in_notify  <= 1'b1;
                    end
                end
                default: begin
                    val_out_notify <= 1'b0;
                    arr_in_notify  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_unpack.sv
// Bench for array_unpack: two instances (FIRST_IDX 0 and 1) share one stimulus;
// outputs are scored against the flattened input stream.
module tb_array_unpack;
    import top_level_types::*;

    localparam int N_BURST = 101;

    logic               clk = 1'b0;
    logic               rst;
    int_2               arr_in;
    logic               arr_in_sync;
    logic               val_out_sync;
    logic               arr_in_notify0, arr_in_notify1;
    logic signed [31:0] val_out0, val_out1;
    logic               val_out_notify0, val_out_notify1;
    logic [1:0]         state_dbg0, state_dbg1;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] src0[N_BURST];
    logic [31:0] src1[N_BURST];
    int n_cmp = 0;
    int n_err = 0;
    int out_cnt0 = 0;
    int out_cnt1 = 0;

    array_unpack #(.FIRST_IDX(0)) dut0 (
        .clk(clk), .rst(rst), .arr_in(arr_in), .arr_in_sync(arr_in_sync),
        .arr_in_notify(arr_in_notify0), .val_out(val_out0),
        .val_out_sync(val_out_sync), .val_out_notify(val_out_notify0),
        .state_dbg(state_dbg0)
    );

    array_unpack #(.FIRST_IDX(1)) dut1 (
        .clk(clk), .rst(rst), .arr_in(arr_in), .arr_in_sync(arr_in_sync),
        .arr_in_notify(arr_in_notify1), .val_out(val_out1),
        .val_out_sync(val_out_sync), .val_out_notify(val_out_notify1),
        .state_dbg(state_dbg1)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_arr(input logic [31:0] a0, input logic [31:0] a1);
        arr_in[0] = a0;
        arr_in[1] = a1;
    endtask

    // scoreboard: each accepted array contributes its elements in emit order
    always @(negedge clk) begin
        if (rst) begin
            check_val("excl0", 32'(arr_in_notify0 & val_out_notify0), 32'd0);
            check_val("excl1", 32'(arr_in_notify1 & val_out_notify1), 32'd0);
            if (arr_in_notify0 && arr_in_sync) begin
                exp_q0.push_back(arr_in[0]);
                exp_q0.push_back(arr_in[1]);
            end
            if (arr_in_notify1 && arr_in_sync) begin
                exp_q1.push_back(arr_in[1]);
                exp_q1.push_back(arr_in[0]);
            end
            if (val_out_notify0 && val_out_sync) begin
                out_cnt0++;
                if (exp_q0.size() == 0) check_val("dut0_q_empty", 32'(exp_q0.size()), 32'd1);
                else check_val("dut0_out", val_out0, exp_q0.pop_front());
            end
            if (val_out_notify1 && val_out_sync) begin
                out_cnt1++;
                if (exp_q1.size() == 0) check_val("dut1_q_empty", 32'(exp_q1.size()), 32'd1);
                else check_val("dut1_out", val_out1, exp_q1.pop_front());
            end
        end
    end

    initial begin
        int idx;
        int budget;
        int base0;
        int base1;

        rst = 1'b0;
        arr_in_sync = 1'b0;
        val_out_sync = 1'b0;
        set_arr(32'd0, 32'd0);
        repeat (3) step();
        check_val("rst_in_notify0", 32'(arr_in_notify0), 32'd1);
        check_val("rst_out_notify0", 32'(val_out_notify0), 32'd0);
        check_val("rst_val0", val_out0, 32'd0);
        check_val("rst_state0", 32'(state_dbg0), 32'd0);
        check_val("rst_in_notify1", 32'(arr_in_notify1), 32'd1);
        check_val("rst_out_notify1", 32'(val_out_notify1), 32'd0);
        rst = 1'b1;
        step();

        // streaming with both syncs high: 5 then -7
        set_arr(32'd5, 32'hFFFF_FFF9);
        arr_in_sync = 1'b1;
        val_out_sync = 1'b1;
        step();
        arr_in_sync = 1'b0;
        check_val("stream_first0", val_out0, 32'd5);
        check_val("stream_first1", val_out1, 32'hFFFF_FFF9);
        check_val("stream_notify", 32'(val_out_notify0), 32'd1);
        check_val("stream_in_busy", 32'(arr_in_notify0), 32'd0);
        step();
        check_val("stream_second0", val_out0, 32'hFFFF_FFF9);
        check_val("stream_second1", val_out1, 32'd5);
        step();
        check_val("stream_in_ready", 32'(arr_in_notify0), 32'd1);
        check_val("stream_out_idle", 32'(val_out_notify0), 32'd0);

        // back-pressure in EMIT0 with a stray input pulse
        val_out_sync = 1'b0;
        set_arr(32'd11, 32'd22);
        arr_in_sync = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                set_arr(32'd99, 32'd98);
                arr_in_sync = 1'b1;
            end else begin
                arr_in_sync = 1'b0;
            end
            step();
            check_val("stall_val0", val_out0, 32'd11);
            check_val("stall_val1", val_out1, 32'd22);
            check_val("stall_in_busy", 32'(arr_in_notify0), 32'd0);
        end
        arr_in_sync = 1'b0;
        val_out_sync = 1'b1;
        step();
        check_val("stall_next0", val_out0, 32'd22);
        check_val("stall_next1", val_out1, 32'd11);
        step();
        check_val("stall_done", 32'(arr_in_notify0), 32'd1);
        val_out_sync = 1'b0;

        // reset while stalled in EMIT1
        set_arr(32'd100, 32'd200);
        arr_in_sync = 1'b1;
        step();
        arr_in_sync = 1'b0;
        val_out_sync = 1'b1;
        step();
        val_out_sync = 1'b0;
        check_val("pre_rst_state", 32'(state_dbg0), 32'd2);
        check_val("pre_rst_val", val_out0, 32'd200);
        #1;
        rst = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        check_val("mid_rst_in_notify", 32'(arr_in_notify0), 32'd1);
        check_val("mid_rst_out_notify", 32'(val_out_notify0), 32'd0);
        check_val("mid_rst_val", val_out0, 32'd0);
        step();
        rst = 1'b1;
        set_arr(32'd1, 32'd2);
        arr_in_sync = 1'b1;
        val_out_sync = 1'b1;
        step();
        arr_in_sync = 1'b0;
        check_val("post_rst_first", val_out0, 32'd1);
        step();
        check_val("post_rst_second", val_out0, 32'd2);
        step();
        check_val("post_rst_ready", 32'(arr_in_notify0), 32'd1);
        val_out_sync = 1'b0;

        // extremes then random burst with random handshakes
        src0[0] = 32'h7FFF_FFFF;
        src1[0] = 32'h8000_0000;
        for (int i = 1; i < N_BURST; i++) begin
            src0[i] = $urandom;
            src1[i] = $urandom;
        end
        base0 = out_cnt0;
        base1 = out_cnt1;
        idx = 0;
        budget = 5000;
        set_arr(src0[0], src1[0]);
        arr_in_sync = 1'b1;
        while (idx < N_BURST && budget > 0) begin
            @(negedge clk);
            if (arr_in_notify0 && arr_in_sync) idx++;
            step();
            budget--;
            if (idx < N_BURST) begin
                set_arr(src0[idx], src1[idx]);
                arr_in_sync = ($urandom_range(0, 3) != 0);
            end else begin
                arr_in_sync = 1'b0;
            end
            val_out_sync = ($urandom_range(0, 2) != 0);
        end
        check_val("burst_all_accepted", 32'(idx), 32'(N_BURST));
        arr_in_sync = 1'b0;
        val_out_sync = 1'b1;
        budget = 100;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && budget > 0) begin
            step();
            budget--;
        end
        step();
        check_val("drain_q0", 32'(exp_q0.size()), 32'd0);
        check_val("drain_q1", 32'(exp_q1.size()), 32'd0);
        check_val("burst_count0", 32'(out_cnt0 - base0), 32'(2 * N_BURST));
        check_val("burst_count1", 32'(out_cnt1 - base1), 32'(2 * N_BURST));
        check_val("end_idle0", 32'(arr_in_notify0), 32'd1);
        val_out_sync = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
